// File: rtl/voice_bank_ctrl_pkg.sv
// voice_bank_ctrl_pkg
//   Shared definitions for the voice bank controller: config-word field
//   offsets, the per-voice envelope state encoding and status-word bit
//   offsets. Imported by voice_bank_ctrl and env_step.
package voice_bank_ctrl_pkg;

  // Config word: [31] cfg, [30:24] tune, [23:16] attack, [15:8] decay,
  // [7:1] note, [0] gate
  localparam int unsigned CFG_BIT    = 31;
  localparam int unsigned TUNE_LSB   = 24;
  localparam int unsigned TUNE_W     = 7;
  localparam int unsigned ATTACK_LSB = 16;
  localparam int unsigned DECAY_LSB  = 8;
  localparam int unsigned RATE_W     = 8;
  localparam int unsigned NOTE_LSB   = 1;
  localparam int unsigned NOTE_W     = 7;
  localparam int unsigned GATE_BIT   = 0;

  // Status word: [31] overrun, [9:8] state, [ENV_W-1:0] level
  localparam int unsigned ST_OVR_BIT   = 31;
  localparam int unsigned ST_STATE_LSB = 8;

  typedef enum logic [1:0] {
    ENV_OFF     = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_HOLD    = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  // Stored voice configuration; packs exactly onto config word bits [30:0]
  typedef struct packed {
    logic [TUNE_W-1:0] tune;
    logic [RATE_W-1:0] attack;
    logic [RATE_W-1:0] decay;
    logic [NOTE_W-1:0] note;
    logic              gate;
  } voice_cfg_t;

endpackage

// File: rtl/voice_bank_ctrl_env_step.sv
// env_step
//   Combinational next-state/next-level computation for one voice visit.
//   Ports:
//     state_in, level_in   current envelope state and level
//     trig                 pending trigger (forces ATTACK from current level)
//     gate                 current gate bit
//     attack, decay        per-visit rates (0 = jump to max / to zero)
//     state_out, level_out values to store for this voice
module env_step
  import voice_bank_ctrl_pkg::*;
#(
  parameter int unsigned ENV_W = 8
) (
  input  logic [1:0]       state_in,
  input  logic [ENV_W-1:0] level_in,
  input  logic             trig,
  input  logic             gate,
  input  logic [7:0]       attack,
  input  logic [7:0]       decay,
  output logic [1:0]       state_out,
  output logic [ENV_W-1:0] level_out
);

  localparam int unsigned SW = ((ENV_W > 8) ? ENV_W : 8) + 1;
  localparam logic [ENV_W-1:0] LVL_MAX = '1;

  env_state_t      st;
  logic [SW-1:0]   sum;

  always_comb begin
    st = env_state_t'(state_in);
    if (trig) st = ENV_ATTACK;
    // A closed gate moves ATTACK/HOLD into RELEASE and the release step is
    // applied within the same visit.
    if ((st == ENV_ATTACK || st == ENV_HOLD) && !gate) st = ENV_RELEASE;

    sum       = SW'(level_in) + SW'(attack);
    state_out = st;
    level_out = level_in;

    case (st)
      ENV_ATTACK: begin
        if (attack == '0 || sum >= SW'(LVL_MAX)) begin
          level_out = LVL_MAX;
          state_out = ENV_HOLD;
        end else begin
          level_out = sum[ENV_W-1:0];
        end
      end
      ENV_RELEASE: begin
        if (decay == '0 || SW'(level_in) <= SW'(decay)) begin
          level_out = '0;
          state_out = ENV_OFF;
        end else begin
          level_out = level_in - ENV_W'(decay);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/voice_bank_ctrl.sv
// voice_bank_ctrl
//   Register bank of NUM_VOICES voice configs plus a time-multiplexed
//   envelope engine that sweeps one voice per cycle on each sample_tick.
//   Optional feature macro: VOICE_BANK_STATUS_READ_EN (status reads return
//   overrun/state/level and clear overrun; otherwise they return 0).
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     addr                MSB=0 config register, MSB=1 status register
//     data_in, wen, ren   write data and held access strobes
//     data_out, ready     read data (valid while ready) and access done
//     sample_tick         envelope sweep request
//     note_out, tune_out, env_out, gate_out  packed per-voice outputs
module voice_bank_ctrl
  import voice_bank_ctrl_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned ENV_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_VOICES):0] addr,
  input  logic [31:0]                 data_in,
  input  logic                        wen,
  input  logic                        ren,
  output logic [31:0]                 data_out,
  output logic                        ready,
  input  logic                        sample_tick,
  output logic [NUM_VOICES*7-1:0]     note_out,
  output logic [NUM_VOICES*7-1:0]     tune_out,
  output logic [NUM_VOICES*ENV_W-1:0] env_out,
  output logic [NUM_VOICES-1:0]       gate_out
);

  localparam int unsigned AW = $clog2(NUM_VOICES) + 1;
  localparam logic [AW-1:0] IDX_MASK = AW'((1 << (AW - 1)) - 1);

  voice_cfg_t      cfg_r   [NUM_VOICES];
  env_state_t      state_r [NUM_VOICES];
  logic [ENV_W-1:0] level_r [NUM_VOICES];
  logic [NUM_VOICES-1:0] trig_r;

  logic        busy;
  logic [4:0]  vcnt;
  logic        overrun;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic        strobe, first, sel_status, in_range, ovr_clr;
  int unsigned idx;
  logic [31:0] rd_word;
  voice_cfg_t  rd_cfg;

  logic [1:0]       vis_state, nxt_state;
  logic [ENV_W-1:0] vis_level, nxt_level;
  logic             vis_trig, vis_gate;
  logic [7:0]       vis_attack, vis_decay;

  assign strobe     = wen | ren;
  assign first      = strobe & ~ready_q;
  assign sel_status = addr[AW-1];
  assign idx        = 32'(addr & IDX_MASK);
  assign in_range   = idx < NUM_VOICES;

  assign ready    = ready_q & strobe;
  assign data_out = ready ? rdata_q : '0;

  // Engine visit mux
  always_comb begin
    vis_state  = state_r[0];
    vis_level  = level_r[0];
    vis_trig   = trig_r[0];
    vis_gate   = cfg_r[0].gate;
    vis_attack = cfg_r[0].attack;
    vis_decay  = cfg_r[0].decay;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (32'(vcnt) == v) begin
        vis_state  = state_r[v];
        vis_level  = level_r[v];
        vis_trig   = trig_r[v];
        vis_gate   = cfg_r[v].gate;
        vis_attack = cfg_r[v].attack;
        vis_decay  = cfg_r[v].decay;
      end
    end
  end

  env_step #(.ENV_W(ENV_W)) u_env_step (
    .state_in  (vis_state),
    .level_in  (vis_level),
    .trig      (vis_trig),
    .gate      (vis_gate),
    .attack    (vis_attack),
    .decay     (vis_decay),
    .state_out (nxt_state),
    .level_out (nxt_level)
  );

`ifdef VOICE_BANK_STATUS_READ_EN
  env_state_t       rd_state;
  logic [ENV_W-1:0] rd_level;
`endif

  // CPU read mux
  always_comb begin
    rd_cfg = cfg_r[0];
`ifdef VOICE_BANK_STATUS_READ_EN
    rd_state = state_r[0];
    rd_level = level_r[0];
`endif
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (idx == v) begin
        rd_cfg = cfg_r[v];
`ifdef VOICE_BANK_STATUS_READ_EN
        rd_state = state_r[v];
        rd_level = level_r[v];
`endif
      end
    end

    rd_word = '0;
    ovr_clr = 1'b0;
    if (!sel_status) begin
      if (in_range) rd_word = {1'b0, rd_cfg};
    end else begin
`ifdef VOICE_BANK_STATUS_READ_EN
      ovr_clr = first & ren;
      if (in_range) begin
        rd_word[ENV_W-1:0]           = rd_level;
        rd_word[ST_STATE_LSB +: 2]   = rd_state;
        rd_word[ST_OVR_BIT]          = overrun;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        cfg_r[v]   <= '0;
        state_r[v] <= ENV_OFF;
        level_r[v] <= '0;
      end
      trig_r  <= '0;
      busy    <= 1'b0;
      vcnt    <= '0;
      overrun <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= strobe;

      if (busy) begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (32'(vcnt) == v) begin
            state_r[v] <= env_state_t'(nxt_state);
            level_r[v] <= nxt_level;
            trig_r[v]  <= 1'b0;
          end
        end
        if (32'(vcnt) == NUM_VOICES - 1) begin
          busy <= 1'b0;
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + 5'd1;
        end
      end else if (sample_tick) begin
        busy <= 1'b1;
        vcnt <= '0;
      end

      // A dropped tick sets overrun even in the cycle a status read clears it
      overrun <= (overrun & ~ovr_clr) | (busy & sample_tick);

      // The visit above used the pre-write config; a trigger set here is
      // placed after the visit's clear so it survives.
      if (first && wen && !sel_status && in_range) begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (idx == v) begin
            if (data_in[CFG_BIT]) begin
              cfg_r[v] <= voice_cfg_t'(data_in[CFG_BIT-1:0]);
            end else begin
              cfg_r[v].note <= data_in[NOTE_LSB +: NOTE_W];
              cfg_r[v].gate <= data_in[GATE_BIT];
            end
            if (data_in[GATE_BIT]) trig_r[v] <= 1'b1;
          end
        end
      end

      if (first && ren) rdata_q <= rd_word;
    end
  end

  always_comb begin
    note_out = '0;
    tune_out = '0;
    env_out  = '0;
    gate_out = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      note_out[v*7 +: 7]         = cfg_r[v].note;
      tune_out[v*7 +: 7]         = cfg_r[v].tune;
      env_out[v*ENV_W +: ENV_W]  = level_r[v];
      gate_out[v]                = cfg_r[v].gate;
    end
  end

endmodule
